// File: rtl/gpio_port.sv
// gpio_port: memory-mapped WIDTH-bit GPIO slave for the FemtoRV32 bus.
//   Registers: OUT, DIR, IN (synchronised pins), SET/CLR/TGL (atomic OUT
//   updates), RISE_EN, FALL_EN, STATUS (sticky edge flags, write-1-to-clear).
// Ports:
//   clk, reset_n       clock, async active-low reset
//   sel, addr, wdata,  bus slave: write when sel & |wmask (byte-lane strobes),
//   wmask, rstrb       read when sel & rstrb
//   rdata              registered read data, valid the cycle after rstrb
//   gpio_in            asynchronous pin inputs
//   gpio_out, gpio_oe  OUT and DIR registers
//   irq                OR of STATUS

// Per-pin input synchroniser plus edge detector.
module gpio_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin,
  input  logic rise_en,
  input  logic fall_en,
  output logic in_sync,
  output logic evt
);
  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], pin};
      prev  <= chain[SYNC_STAGES-1];
    end
  end

  assign in_sync = chain[SYNC_STAGES-1];
  assign evt     = (in_sync & ~prev & rise_en) | (~in_sync & prev & fall_en);
endmodule

module gpio_port #(
  parameter int               WIDTH       = 5,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] OUT_RESET   = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0] DIR_RESET   = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sel,
  input  logic [5:0]       addr,
  input  logic [31:0]      wdata,
  input  logic [3:0]       wmask,
  input  logic             rstrb,
  output logic [31:0]      rdata,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);
  localparam logic [3:0] A_OUT = 4'd0, A_DIR = 4'd1, A_IN = 4'd2, A_SET = 4'd3,
                         A_CLR = 4'd4, A_TGL = 4'd5, A_REN = 4'd6, A_FEN = 4'd7,
                         A_STS = 4'd8;

  logic [WIDTH-1:0] out_q, dir_q, ren_q, fen_q, sts_q;
  logic [WIDTH-1:0] out_n, dir_n, ren_n, fen_n, sts_n;
  logic [WIDTH-1:0] in_sync, evt, w1c;
  logic [31:0]      lane_m, wd, rd_val;
  logic [WIDTH-1:0] lm_w, wd_w;
  logic [3:0]       idx;
  logic             we, re;

  assign idx  = addr[5:2];
  assign we   = sel & (|wmask);
  assign re   = sel & rstrb;

  // Byte strobes widened to a bit mask; masked-off lanes read as zero data.
  assign lane_m = {{8{wmask[3]}}, {8{wmask[2]}}, {8{wmask[1]}}, {8{wmask[0]}}};
  assign wd     = wdata & lane_m;
  assign lm_w   = lane_m[WIDTH-1:0];
  assign wd_w   = wd[WIDTH-1:0];

  logic unused_ok;
  assign unused_ok = ^{addr[1:0], wd, lane_m};

  genvar g;
  generate
    for (g = 0; g < WIDTH; g++) begin : g_pin
      gpio_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_pin (
        .clk     (clk),
        .reset_n (reset_n),
        .pin     (gpio_in[g]),
        .rise_en (ren_q[g]),
        .fall_en (fen_q[g]),
        .in_sync (in_sync[g]),
        .evt     (evt[g])
      );
    end
  endgenerate

  always_comb begin
    out_n = out_q;
    dir_n = dir_q;
    ren_n = ren_q;
    fen_n = fen_q;
    w1c   = '0;
    if (we) begin
      case (idx)
        A_OUT:   out_n = (out_q & ~lm_w) | wd_w;
        A_DIR:   dir_n = (dir_q & ~lm_w) | wd_w;
        A_SET:   out_n = out_q | wd_w;
        A_CLR:   out_n = out_q & ~wd_w;
        A_TGL:   out_n = out_q ^ wd_w;
        A_REN:   ren_n = (ren_q & ~lm_w) | wd_w;
        A_FEN:   fen_n = (fen_q & ~lm_w) | wd_w;
        A_STS:   w1c   = wd_w;
        default: ;
      endcase
    end
    // A new edge wins over a simultaneous clear of the same bit.
    sts_n = (sts_q & ~w1c) | evt;
  end

  always_comb begin
    rd_val = '0;
    case (idx)
      A_OUT:   rd_val[WIDTH-1:0] = out_q;
      A_DIR:   rd_val[WIDTH-1:0] = dir_q;
      A_IN:    rd_val[WIDTH-1:0] = in_sync;
      A_REN:   rd_val[WIDTH-1:0] = ren_q;
      A_FEN:   rd_val[WIDTH-1:0] = fen_q;
      A_STS:   rd_val[WIDTH-1:0] = sts_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q <= OUT_RESET;
      dir_q <= DIR_RESET;
      ren_q <= '0;
      fen_q <= '0;
      sts_q <= '0;
      rdata <= '0;
    end else begin
      out_q <= out_n;
      dir_q <= dir_n;
      ren_q <= ren_n;
      fen_q <= fen_n;
      sts_q <= sts_n;
      // Sampled from current state, so a same-cycle write reads back old data.
      if (re) rdata <= rd_val;
    end
  end

  assign gpio_out = out_q;
  assign gpio_oe  = dir_q;
  assign irq      = |sts_q;
endmodule

// File: doc/gpio_port.md
# gpio_port

Parametrised memory-mapped GPIO peripheral for the FemtoRV32 SoC bus; replaces the fixed 5-bit LED write-only register with a WIDTH-bit port. Provides output data, per-pin direction, atomic set/clear/toggle, synchronised input readback and per-pin edge interrupts. Sits behind the address decoder as a bus slave with registered read data and no wait states; `gpio_out`/`gpio_oe` drive pads or LEDs, and `irq` goes to the interrupt line.

## Interface
- WIDTH, 5, number of GPIO pins, 1..32
- SYNC_STAGES, 2, input synchroniser depth, 2..3
- OUT_RESET, {WIDTH{1'b0}}, reset value of OUT
- DIR_RESET, {WIDTH{1'b0}}, reset value of DIR (1 = output)
- clk  in  1  clock
- reset_n  in  1  reset, asynchronous, active-low
- sel  in  1  slave selected by address decoder
- addr  in  6  byte offset; [5:2] word index, [1:0] ignored
- wdata  in  32  write data
- wmask  in  4  byte-lane write strobes; any bit set with sel = write
- rstrb  in  1  read strobe, qualified by sel
- rdata  out  32  registered read data
- gpio_in  in  WIDTH  asynchronous pin inputs
- gpio_out  out  WIDTH  OUT register
- gpio_oe  out  WIDTH  DIR register
- irq  out  1  OR of STATUS

## Operation
- Register map (offset, access):
  - 0x00 OUT, RW
  - 0x04 DIR, RW
  - 0x08 IN, RO: synchronised pins
  - 0x0C SET, WO: OUT |= data
  - 0x10 CLR, WO: OUT &= ~data
  - 0x14 TGL, WO: OUT ^= data
  - 0x18 RISE_EN, RW
  - 0x1C FALL_EN, RW
  - 0x20 STATUS, R/W1C
- RW registers update only the byte lanes set in wmask. For SET/CLR/TGL/STATUS, masked-off lanes count as zero data.
- Bits at and above WIDTH: writes ignored, reads 0.
- Reads of SET/CLR/TGL, unmapped offsets (0x24..0x3C) and writes to IN/unmapped offsets: reads return 0, writes have no effect.
- Input path: gpio_in → SYNC_STAGES flops → `in_sync`, plus one further flop `in_prev`.
  - rise = in_sync & ~in_prev & RISE_EN
  - fall = ~in_sync & in_prev & FALL_EN
- STATUS[i] is sticky. It is set by rise[i]|fall[i] and cleared by a W1C write.
  - A set and a clear of the same bit in the same cycle leaves the bit set.
- `irq` = |STATUS. It is combinational from the register, with no extra delay.
- Direction does not gate IN: output pins read back their pad value.

## Timing
- Reset values:
  - OUT = OUT_RESET, DIR = DIR_RESET; `gpio_out` and `gpio_oe` follow these.
  - RISE_EN = FALL_EN = STATUS = 0.
  - Sync chain and in_prev = 0.
  - rdata = 0, irq = 0.
- Writes: the register updates on the clk edge where sel & |wmask. The new value is visible on `gpio_out`/`gpio_oe` immediately after that edge.
- Reads: rdata is loaded on the edge where sel & rstrb and is valid from the next cycle. It holds until the next read strobe, which is the 1-cycle latency required by FemtoRV32 with mem_rbusy = 0.
- Read and write in the same cycle: rdata returns the pre-write value.
- Input latency: a pin change stable before edge 0 appears in in_sync after SYNC_STAGES edges. The STATUS bit and irq assert one edge later (SYNC_STAGES+1 edges).
- Pulses shorter than one clk period may be missed; no requirement applies to them.
- reset_n asserted mid-operation clears all state asynchronously, including any pending STATUS bit. No edge is reported for a pin held high across reset unless RISE_EN was set after release; the sync chain then rises from 0.

## Test plan
- Reset with OUT_RESET = 5'h15, WIDTH = 5 → gpio_out = 5'h15, gpio_oe = 0, irq = 0; read of 0x00 returns 32'h15.
- Write OUT = 32'hFFFF_FFFF with wmask = 4'b0001, WIDTH = 5 → gpio_out = 5'h1F; readback = 32'h1F (upper bits 0).
- OUT = 5'h0A, then SET 5'h01, CLR 5'h08, TGL 5'h1F on consecutive cycles → gpio_out = 5'h0B, then 5'h03, then 5'h1C.
- RISE_EN = 5'h04; drive gpio_in[2] 0→1 → STATUS = 5'h04 and irq = 1 exactly SYNC_STAGES+1 edges later. A falling edge on pin 2 does not add a bit. W1C 5'h04 → irq = 0 next cycle.
- Rising edge reaching STATUS on the same edge as a W1C of that bit → bit stays 1, irq stays 1.
- Read of 0x0C and of 0x3C → rdata = 0 one cycle after rstrb; an IN read reflects gpio_in after SYNC_STAGES edges.
